// File: rtl/pipe_stage_reg_if.sv
// Handshake/bus bundle between two pipeline stages and the stage register that
// separates them: upstream drives In_* plus Stall/Flush, the register drives Out_* and counters.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
);
    logic              Stall;
    logic              Flush;
    logic              In_Valid;
    logic [CTRL_W-1:0] In_Ctrl;
    logic [DATA_W-1:0] In_Data;
    logic              Out_Valid;
    logic [CTRL_W-1:0] Out_Ctrl;
    logic [DATA_W-1:0] Out_Data;
    logic [CNT_W-1:0]  Stall_Cnt;
    logic [CNT_W-1:0]  Bubble_Cnt;

    modport master (
        output Stall, Flush, In_Valid, In_Ctrl, In_Data,
        input  Out_Valid, Out_Ctrl, Out_Data, Stall_Cnt, Bubble_Cnt
    );

    modport slave (
        input  Stall, Flush, In_Valid, In_Ctrl, In_Data,
        output Out_Valid, Out_Ctrl, Out_Data, Stall_Cnt, Bubble_Cnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: DEPTH valid-tagged slices with
// stall, flush (bubble insertion), selectable capture edge and saturating counters.
module pipe_stage_reg #(
    parameter int DATA_W   = 64,
    parameter int CTRL_W   = 8,
    parameter int DEPTH    = 1,
    parameter int NEG_EDGE = 1,
    parameter int CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    pipe_stage_reg_if.slave  bus
);

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
            $error("pipe_stage_reg: DEPTH must be in 1..4");
        end
    endgenerate

    // Falling-edge capture is done by inverting the clock once here so every
    // flop below stays a plain posedge flop on a single clock net.
    logic clk_act;
    assign clk_act = (NEG_EDGE != 0) ? ~Clk : Clk;

    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0][CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q,  data_d;
    logic [CNT_W-1:0]             stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0]             bubble_cnt_q, bubble_cnt_d;
    logic                         enter_valid;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    generate
        if (DEPTH == 1) begin : g_enter_in
            assign enter_valid = bus.In_Valid;
        end else begin : g_enter_slice
            assign enter_valid = valid_q[DEPTH-2];
        end
    endgenerate

    always_comb begin
        // NOTE: every _d takes its held value first, so no path through this block can infer a latch.
        valid_d      = valid_q;
        ctrl_d       = ctrl_q;
        data_d       = data_q;
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;

        if (bus.Flush) begin
            valid_d      = '0;
            ctrl_d       = '0;
            bubble_cnt_d = sat_inc(bubble_cnt_q);
        end else if (bus.Stall) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            if (!enter_valid) begin
                bubble_cnt_d = sat_inc(bubble_cnt_q);
            end
            for (int k = DEPTH - 1; k > 0; k--) begin
                valid_d[k] = valid_q[k-1];
                ctrl_d[k]  = ctrl_q[k-1];
                data_d[k]  = data_q[k-1];
            end
            valid_d[0] = bus.In_Valid;
            ctrl_d[0]  = bus.In_Valid ? bus.In_Ctrl : '0;
            data_d[0]  = bus.In_Data;
        end
    end

    // NOTE: the data slices are reset too, so all outputs read 0 after Rst rather than stale data.
    always_ff @(posedge clk_act) begin
        if (Rst) begin
            valid_q      <= '0;
            ctrl_q       <= '0;
            data_q       <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking so all slices sample the previous edge's values together.
            valid_q      <= valid_d;
            ctrl_q       <= ctrl_d;
            data_q       <= data_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.Out_Valid  = valid_q[DEPTH-1];
    assign bus.Out_Ctrl   = valid_q[DEPTH-1] ? ctrl_q[DEPTH-1] : '0;
    assign bus.Out_Data   = data_q[DEPTH-1];
    assign bus.Stall_Cnt  = stall_cnt_q;
    assign bus.Bubble_Cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: three pipe_stage_reg configurations share one stimulus stream and are
// compared against a queue-style reference model, plus a vector table and directed sequences.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic        v;
        logic [7:0]  c;
        logic [63:0] d;
    } bundle_t;

    typedef struct {
        logic        rst, stall, flush, v;
        logic [7:0]  c;
        logic [63:0] d;
        logic        ev;
        logic [7:0]  ec;
        logic [63:0] ed;
        int          esc, ebc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1, stall = 1'b0, flush = 1'b0, in_valid = 1'b0;
    logic [7:0]  in_ctrl = '0;
    logic [63:0] in_data = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Instance 0: DEPTH=2, falling edge, 16-bit counters
    pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(8), .CNT_W(16)) if_a ();
    // Instance 1: DEPTH=1, falling edge, 4-bit counters
    pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(8), .CNT_W(4))  if_b ();
    // Instance 2: DEPTH=3, rising edge, 4-bit counters
    pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(8), .CNT_W(4))  if_c ();

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .DEPTH(2), .NEG_EDGE(1), .CNT_W(16))
        u_a (.Clk(clk), .Rst(rst), .bus(if_a.slave));
    pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .DEPTH(1), .NEG_EDGE(1), .CNT_W(4))
        u_b (.Clk(clk), .Rst(rst), .bus(if_b.slave));
    pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .DEPTH(3), .NEG_EDGE(0), .CNT_W(4))
        u_c (.Clk(clk), .Rst(rst), .bus(if_c.slave));

    assign if_a.Stall = stall;  assign if_a.Flush = flush;  assign if_a.In_Valid = in_valid;
    assign if_a.In_Ctrl = in_ctrl;  assign if_a.In_Data = in_data;
    assign if_b.Stall = stall;  assign if_b.Flush = flush;  assign if_b.In_Valid = in_valid;
    assign if_b.In_Ctrl = in_ctrl;  assign if_b.In_Data = in_data;
    assign if_c.Stall = stall;  assign if_c.Flush = flush;  assign if_c.In_Valid = in_valid;
    assign if_c.In_Ctrl = in_ctrl;  assign if_c.In_Data = in_data;

    logic        o_v  [3];
    logic [7:0]  o_c  [3];
    logic [63:0] o_d  [3];
    logic [15:0] o_sc [3];
    logic [15:0] o_bc [3];

    assign o_v[0] = if_a.Out_Valid;  assign o_c[0] = if_a.Out_Ctrl;  assign o_d[0] = if_a.Out_Data;
    assign o_sc[0] = if_a.Stall_Cnt; assign o_bc[0] = if_a.Bubble_Cnt;
    assign o_v[1] = if_b.Out_Valid;  assign o_c[1] = if_b.Out_Ctrl;  assign o_d[1] = if_b.Out_Data;
    assign o_sc[1] = {12'h0, if_b.Stall_Cnt}; assign o_bc[1] = {12'h0, if_b.Bubble_Cnt};
    assign o_v[2] = if_c.Out_Valid;  assign o_c[2] = if_c.Out_Ctrl;  assign o_d[2] = if_c.Out_Data;
    assign o_sc[2] = {12'h0, if_c.Stall_Cnt}; assign o_bc[2] = {12'h0, if_c.Bubble_Cnt};

    // Reference model: per instance, the list of bundles in flight (index 0 = newest)
    bundle_t m      [3][4];
    int      m_sc   [3];
    int      m_bc   [3];
    int      depth_of [3];
    int      cmax     [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    task automatic model_step();
        bundle_t nb;
        bundle_t entering;
        nb = '{v: in_valid, c: (in_valid ? in_ctrl : 8'h00), d: in_data};
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                for (int k = 0; k < 4; k++) m[i][k] = '0;
                m_sc[i] = 0;
                m_bc[i] = 0;
            end else if (flush) begin
                for (int k = 0; k < depth_of[i]; k++) begin
                    m[i][k].v = 1'b0;
                    m[i][k].c = 8'h00;
                end
                m_bc[i] = sat(m_bc[i], cmax[i]);
            end else if (stall) begin
                m_sc[i] = sat(m_sc[i], cmax[i]);
            end else begin
                if (depth_of[i] == 1) entering = nb;
                else                  entering = m[i][depth_of[i]-2];
                if (!entering.v) m_bc[i] = sat(m_bc[i], cmax[i]);
                for (int k = depth_of[i] - 1; k > 0; k--) m[i][k] = m[i][k-1];
                m[i][0] = nb;
            end
        end
    endtask

    task automatic model_compare();
        bundle_t e;
        for (int i = 0; i < 3; i++) begin
            e = m[i][depth_of[i]-1];
            check($sformatf("model u%0d valid", i), 64'(o_v[i]), 64'(e.v));
            check($sformatf("model u%0d ctrl", i),  64'(o_c[i]), 64'(e.c));
            check($sformatf("model u%0d data", i),  o_d[i], e.d);
            check($sformatf("model u%0d stall_cnt", i),  64'(o_sc[i]), 64'(m_sc[i]));
            check($sformatf("model u%0d bubble_cnt", i), 64'(o_bc[i]), 64'(m_bc[i]));
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic f, input logic v,
                         input logic [7:0] c, input logic [63:0] d);
        rst = r; stall = s; flush = f; in_valid = v; in_ctrl = c; in_data = d;
    endtask

    // One full clock period: rising edge then falling edge; model stepped and compared after both
    task automatic cycle();
        @(posedge clk); #1;
        @(negedge clk); #1;
        model_step();
        model_compare();
    endtask

    vec_t tbl [11];

    initial begin
        depth_of = '{2, 1, 3};
        cmax     = '{65535, 15, 15};
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 4; k++) m[i][k] = '0;
            m_sc[i] = 0;
            m_bc[i] = 0;
        end

        //            rst stall flush v  ctrl   data        ev  ectrl  edata     esc ebc
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 64'h0,    1'b0, 8'h00, 64'h0,    0, 0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h03, 64'h1234, 1'b0, 8'h00, 64'h0,    0, 1};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 64'h5555, 1'b1, 8'h03, 64'h1234, 0, 1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 64'h6666, 1'b0, 8'h00, 64'h5555, 0, 2};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 64'h7777, 1'b0, 8'h00, 64'h6666, 0, 3};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 64'h8888, 1'b1, 8'hA5, 64'h7777, 0, 3};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 64'h9999, 1'b0, 8'h00, 64'h7777, 0, 4};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h22, 64'hAAAA, 1'b0, 8'h00, 64'h7777, 1, 4};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 64'hBBBB, 1'b0, 8'h00, 64'h8888, 1, 5};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h44, 64'hCCCC, 1'b1, 8'h33, 64'hBBBB, 1, 5};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 64'hDDDD, 1'b0, 8'h00, 64'h0,    0, 0};

        // Reset with a full pipe of valid A5 bundles
        drive(1, 0, 0, 0, 8'h00, 64'h0);
        cycle();
        for (int n = 0; n < 3; n++) begin
            drive(0, 0, 0, 1, 8'hA5, 64'h4000 + 64'(n));
            cycle();
        end
        check("fill valid before reset", 64'(o_v[0]), 64'h1);

        // Vector table on the DEPTH=2 instance (row 0 is the reset edge)
        for (int r = 0; r < 11; r++) begin
            drive(tbl[r].rst, tbl[r].stall, tbl[r].flush, tbl[r].v, tbl[r].c, tbl[r].d);
            cycle();
            check($sformatf("tbl[%0d] valid", r), 64'(o_v[0]), 64'(tbl[r].ev));
            check($sformatf("tbl[%0d] ctrl", r),  64'(o_c[0]), 64'(tbl[r].ec));
            check($sformatf("tbl[%0d] data", r),  o_d[0], tbl[r].ed);
            check($sformatf("tbl[%0d] stall_cnt", r),  64'(o_sc[0]), 64'(tbl[r].esc));
            check($sformatf("tbl[%0d] bubble_cnt", r), 64'(o_bc[0]), 64'(tbl[r].ebc));
        end

        // Stall hold on DEPTH=1: capture BEEF, stall three edges with DEAD presented
        drive(1, 0, 0, 0, 8'h00, 64'h0);
        cycle();
        drive(0, 0, 0, 1, 8'h12, 64'hBEEF);
        cycle();
        check("stall capture data", o_d[1], 64'hBEEF);
        drive(0, 1, 0, 1, 8'h34, 64'hDEAD);
        for (int n = 0; n < 3; n++) cycle();
        check("stall hold data", o_d[1], 64'hBEEF);
        check("stall hold valid", 64'(o_v[1]), 64'h1);
        check("stall count 3", 64'(o_sc[1]), 64'd3);
        drive(0, 0, 0, 1, 8'h34, 64'hDEAD);
        cycle();
        check("stall release data", o_d[1], 64'hDEAD);
        check("stall release ctrl", 64'(o_c[1]), 64'h34);

        // Saturation: 20 more stalled edges; 4-bit counters stop at 15
        drive(0, 1, 0, 0, 8'h00, 64'h0);
        for (int n = 0; n < 20; n++) cycle();
        check("sat u1 stall_cnt", 64'(o_sc[1]), 64'd15);
        check("sat u2 stall_cnt", 64'(o_sc[2]), 64'd15);
        check("nosat u0 stall_cnt", 64'(o_sc[0]), 64'd23);

        // Edge selection: after a rising edge only the rising-edge instance has counted
        drive(1, 0, 0, 0, 8'h00, 64'h0);
        cycle();
        drive(0, 1, 0, 0, 8'h00, 64'h0);
        @(posedge clk); #1;
        check("rise edge u2 stall_cnt", 64'(o_sc[2]), 64'd1);
        check("rise edge u0 stall_cnt", 64'(o_sc[0]), 64'd0);
        check("rise edge u1 stall_cnt", 64'(o_sc[1]), 64'd0);
        @(negedge clk); #1;
        model_step();
        model_compare();
        check("fall edge u0 stall_cnt", 64'(o_sc[0]), 64'd1);
        check("fall edge u2 stall_cnt", 64'(o_sc[2]), 64'd1);

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 1)),
                  8'($urandom),
                  {$urandom, $urandom});
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
